pll_reset_sequencer: RTL and testbench

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

---
 rtl/pll_reset_sequencer.sv | 147 ++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses pll_rst, waits for a stable synchronized lock, then releases
// three output reset domains in staggered order. Optional macro PLL_SEQ_RETRY_CNT_EN adds retry_cnt.
module pll_reset_sequencer #(
  parameter int unsigned RST_CYCLES     = 16,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 65536,
  parameter int unsigned STAGE_GAP      = 8
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic [2:0] rst_out,
  output logic       ready
`ifdef PLL_SEQ_RETRY_CNT_EN
  ,
  output logic [7:0] retry_cnt
`endif
);

  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_e;

  localparam logic [19:0] RST_LAST    = 20'(RST_CYCLES - 1);
  localparam logic [19:0] STABLE_LIM  = 20'(STABLE_CYCLES);
  localparam logic [19:0] TIMEOUT_LIM = 20'(TIMEOUT_CYCLES);
  localparam logic [19:0] GAP_ONE     = 20'(STAGE_GAP);
  localparam logic [19:0] GAP_TWO     = 20'(2 * STAGE_GAP);
  localparam logic [19:0] CNT_MAX     = 20'hFFFFF;

  state_e      state_q, state_d;
  logic [19:0] cyc_q, cyc_d, cyc_inc;
  logic [19:0] stab_q, stab_d, stab_inc;
  logic [1:0]  sync_q, sync_d;
  logic        pll_rst_q, pll_rst_d;
  logic [2:0]  rst_out_q, rst_out_d;
  logic        ready_q, ready_d;
  logic        locked_s;
  logic        release_hit, timeout_hit, lock_lost;

  assign locked_s = sync_q[1];

  always_comb begin
    sync_d      = {sync_q[0], locked};
    state_d     = state_q;
    cyc_inc     = (cyc_q == CNT_MAX) ? cyc_q : cyc_q + 20'd1;
    stab_inc    = (stab_q == CNT_MAX) ? stab_q : stab_q + 20'd1;
    cyc_d       = cyc_inc;
    stab_d      = '0;
    release_hit = 1'b0;
    timeout_hit = 1'b0;
    lock_lost   = 1'b0;
    case (state_q)
      RESET_PLL: begin
        if (restart) begin
          cyc_d = '0;
        end else if (cyc_q == RST_LAST) begin
          state_d = WAIT_LOCK;
          cyc_d   = '0;
        end
      end
      WAIT_LOCK: begin
        stab_d      = locked_s ? stab_inc : '0;
        release_hit = (stab_d == STABLE_LIM);
        timeout_hit = (cyc_inc == TIMEOUT_LIM);
        // Reaching the stable count takes precedence over a simultaneous timeout.
        if (restart || release_hit || timeout_hit) begin
          state_d = (!restart && release_hit) ? RELEASE : RESET_PLL;
          cyc_d   = '0;
          stab_d  = '0;
        end
      end
      RELEASE, RUN: begin
        lock_lost = !locked_s;
        if (lock_lost || restart) begin
          state_d = RESET_PLL;
          cyc_d   = '0;
        end else if (state_q == RELEASE && cyc_q == GAP_TWO) begin
          state_d = RUN;
          cyc_d   = '0;
        end
      end
      default: begin
        state_d = RESET_PLL;
        cyc_d   = '0;
      end
    endcase

    // Outputs are registered from the next state so they line up with state_q.
    pll_rst_d = (state_d == RESET_PLL);
    ready_d   = (state_d == RUN);
    case (state_d)
      RELEASE: rst_out_d = {cyc_d < GAP_TWO, cyc_d < GAP_ONE, 1'b0};
      RUN:     rst_out_d = 3'b000;
      default: rst_out_d = 3'b111;
    endcase
  end

`ifdef PLL_SEQ_RETRY_CNT_EN
  logic [7:0] retry_q, retry_d;
  logic       retry_bump;

  // Restart alone never counts; a lock loss coinciding with restart counts once.
  always_comb begin
    retry_bump = (state_q == WAIT_LOCK && !restart && !release_hit && timeout_hit) ||
                 lock_lost;
    retry_d    = (retry_bump && retry_q != 8'hFF) ? retry_q + 8'd1 : retry_q;
  end

  always_ff @(posedge refclk) begin
    if (rst) retry_q <= '0;
    else     retry_q <= retry_d;
  end

  assign retry_cnt = retry_q;
`endif

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= RESET_PLL;
      cyc_q     <= '0;
      stab_q    <= '0;
      sync_q    <= '0;
      pll_rst_q <= 1'b1;
      rst_out_q <= 3'b111;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      stab_q    <= stab_d;
      sync_q    <= sync_d;
      pll_rst_q <= pll_rst_d;
      rst_out_q <= rst_out_d;
      ready_q   <= ready_d;
    end
  end

  assign pll_rst = pll_rst_q;
  assign rst_out = rst_out_q;
  assign ready   = ready_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer with small timing parameters; a phase/elapsed-time reference
// model predicts pll_rst, rst_out, ready (and retry_cnt when PLL_SEQ_RETRY_CNT_EN is defined).
module tb_pll_reset_sequencer;

  localparam int RSTC = 4;
  localparam int STAB = 8;
  localparam int TMO  = 32;
  localparam int GAP  = 2;

  logic       refclk = 1'b0;
  logic       rst, locked, restart;
  logic       pll_rst, ready;
  logic [2:0] rst_out;
`ifdef PLL_SEQ_RETRY_CNT_EN
  logic [7:0] retry_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // Model: phase 0=pll reset, 1=wait lock, 2=staged release, 3=run; m_t = cycles spent in phase.
  int m_phase, m_t, m_run, m_retry;
  bit m_l1, m_l2;

  pll_reset_sequencer #(
    .RST_CYCLES(RSTC), .STABLE_CYCLES(STAB), .TIMEOUT_CYCLES(TMO), .STAGE_GAP(GAP)
  ) dut (
    .refclk (refclk),
    .rst    (rst),
    .locked (locked),
    .restart(restart),
    .pll_rst(pll_rst),
    .rst_out(rst_out),
    .ready  (ready)
`ifdef PLL_SEQ_RETRY_CNT_EN
    ,
    .retry_cnt(retry_cnt)
`endif
  );

  // ---------------- clock ----------------
  always #5 refclk = ~refclk;

  // ---------------- reference model ----------------
  function automatic logic [4:0] exp_outs();
    int         rel;
    logic [2:0] ro;
    case (m_phase)
      0: return {1'b1, 3'b111, 1'b0};
      1: return {1'b0, 3'b111, 1'b0};
      2: begin
        rel = m_t / GAP + 1;
        if (rel > 3) rel = 3;
        ro = 3'(7 << rel);
        return {1'b0, ro, 1'b0};
      end
      default: return {1'b0, 3'b000, 1'b1};
    endcase
  endfunction

  task automatic go_reset_phase(input bit count_retry);
    m_phase = 0;
    m_t     = 0;
    m_run   = 0;
    if (count_retry && m_retry < 255) m_retry++;
  endtask

  task automatic model_tick(input bit r, input bit l, input bit rs);
    int nr;
    if (r) begin
      go_reset_phase(1'b0);
      m_retry = 0;
      m_l1 = 1'b0;
      m_l2 = 1'b0;
      return;
    end
    case (m_phase)
      0: begin
        if (rs) m_t = 0;
        else if (m_t + 1 == RSTC) begin m_phase = 1; m_t = 0; m_run = 0; end
        else m_t++;
      end
      1: begin
        nr = m_l2 ? m_run + 1 : 0;
        if (rs) go_reset_phase(1'b0);
        else if (nr == STAB) begin m_phase = 2; m_t = 0; m_run = 0; end
        else if (m_t + 1 == TMO) go_reset_phase(1'b1);
        else begin m_t++; m_run = nr; end
      end
      default: begin
        if (!m_l2) go_reset_phase(1'b1);
        else if (rs) go_reset_phase(1'b0);
        else if (m_phase == 2 && m_t == 2 * GAP) begin m_phase = 3; m_t = 0; end
        else m_t++;
      end
    endcase
    m_l2 = m_l1;
    m_l1 = l;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge refclk);
    model_tick(rst, locked, restart);
    @(negedge refclk);
  endtask

  // Leaves the bench at sample 0: the first cycle after rst is released.
  task automatic do_reset();
    rst = 1'b1;
    restart = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      locked  = 1'($urandom_range(0, 1));
      restart = 1'($urandom_range(0, 1));
      step();
      n_checks++;
      if ({pll_rst, rst_out, ready} !== 5'b1_111_0)
        $display("FAIL reset_outputs cyc %0d: got %b want %b", i, {pll_rst, rst_out, ready}, 5'b1_111_0);
      else n_pass++;
    end
`ifdef PLL_SEQ_RETRY_CNT_EN
    n_checks++;
    if (retry_cnt !== 8'd0) $display("FAIL reset_retry: got %0d want 0", retry_cnt);
    else n_pass++;
`endif
    restart = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_lock_held();
    int hi = 0, f110 = -1, f100 = -1, f000 = -1, frdy = -1;
    locked = 1'b1;
    do_reset();
    for (int i = 0; i < 30; i++) begin
      n_checks++;
      if ({pll_rst, rst_out, ready} !== exp_outs())
        $display("FAIL lock_held cyc %0d: got %b want %b", i, {pll_rst, rst_out, ready}, exp_outs());
      else n_pass++;
      hi += int'(pll_rst);
      if (rst_out == 3'b110 && f110 < 0) f110 = i;
      if (rst_out == 3'b100 && f100 < 0) f100 = i;
      if (rst_out == 3'b000 && f000 < 0) f000 = i;
      if (ready && frdy < 0) frdy = i;
      step();
    end
    n_checks++;
    if (hi != RSTC) $display("FAIL lock_held_pll_rst_len: got %0d want %0d", hi, RSTC);
    else n_pass++;
    n_checks++;
    if (f110 != 12 || f100 != 14 || f000 != 16 || frdy != 17)
      $display("FAIL lock_held_stagger: got 110@%0d 100@%0d 000@%0d rdy@%0d want 12 14 16 17",
               f110, f100, f000, frdy);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int rises = 0, first = -1, last = -1;
    bit bad_gap = 1'b0;
    logic prev = 1'b1;
    locked = 1'b0;
    do_reset();
    for (int i = 0; i < 112; i++) begin
      n_checks++;
      if ({pll_rst, rst_out, ready} !== exp_outs())
        $display("FAIL timeout cyc %0d: got %b want %b", i, {pll_rst, rst_out, ready}, exp_outs());
      else n_pass++;
      if (pll_rst && !prev) begin
        if (last >= 0 && i - last != RSTC + TMO) bad_gap = 1'b1;
        if (first < 0) first = i;
        last = i;
        rises++;
      end
      prev = pll_rst;
      step();
    end
    n_checks++;
    if (rises != 3 || first != RSTC + TMO || bad_gap)
      $display("FAIL timeout_period: got rises %0d first %0d gap_err %0d want 3 36 0", rises, first, bad_gap);
    else n_pass++;
`ifdef PLL_SEQ_RETRY_CNT_EN
    n_checks++;
    if (retry_cnt !== 8'd3) $display("FAIL timeout_retry: got %0d want 3", retry_cnt);
    else n_pass++;
`endif
  endtask

  task automatic test_glitch();
    int f110 = -1;
    locked = 1'b1;
    do_reset();
    for (int i = 0; i < 30; i++) begin
      n_checks++;
      if ({pll_rst, rst_out, ready} !== exp_outs())
        $display("FAIL glitch cyc %0d: got %b want %b", i, {pll_rst, rst_out, ready}, exp_outs());
      else n_pass++;
      if (rst_out == 3'b110 && f110 < 0) f110 = i;
      locked = (i != 9);
      step();
    end
    n_checks++;
    if (f110 != 20) $display("FAIL glitch_release_delay: got %0d want 20", f110);
    else n_pass++;
  endtask

  task automatic test_lock_loss();
    int edges = 0, hi = 0;
    locked = 1'b1;
    do_reset();
    repeat (20) step();
    locked = 1'b0;
    while (rst_out !== 3'b111 && edges < 10) begin
      step();
      edges++;
    end
    n_checks++;
    if (edges != 3 || ready !== 1'b0)
      $display("FAIL lock_loss_latency: got %0d edges ready %b want 3 edges ready 0", edges, ready);
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if ({pll_rst, rst_out, ready} !== exp_outs())
        $display("FAIL lock_loss cyc %0d: got %b want %b", i, {pll_rst, rst_out, ready}, exp_outs());
      else n_pass++;
      hi += int'(pll_rst);
      step();
    end
    n_checks++;
    if (hi != RSTC) $display("FAIL lock_loss_pll_rst_len: got %0d want %0d", hi, RSTC);
    else n_pass++;
  endtask

  task automatic test_restart_with_loss();
    int rises = 0;
    logic prev = 1'b0;
    locked = 1'b1;
    do_reset();
    repeat (20) step();
    locked = 1'b0;
    step();
    step();
    restart = 1'b1;
    step();
    restart = 1'b0;
    for (int i = 0; i < 12; i++) begin
      n_checks++;
      if ({pll_rst, rst_out, ready} !== exp_outs())
        $display("FAIL restart_loss cyc %0d: got %b want %b", i, {pll_rst, rst_out, ready}, exp_outs());
      else n_pass++;
      if (pll_rst && !prev) rises++;
      prev = pll_rst;
      step();
    end
    n_checks++;
    if (rises != 1) $display("FAIL restart_loss_entries: got %0d want 1", rises);
    else n_pass++;
`ifdef PLL_SEQ_RETRY_CNT_EN
    n_checks++;
    if (retry_cnt !== 8'd1) $display("FAIL restart_loss_retry: got %0d want 1", retry_cnt);
    else n_pass++;
`endif
  endtask

  task automatic test_restart_in_reset();
    int hi = 0;
    locked = 1'b1;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      hi += int'(pll_rst);
      restart = (i == 2);
      step();
    end
    restart = 1'b0;
    n_checks++;
    if (hi != 7) $display("FAIL restart_in_reset_len: got %0d want 7", hi);
    else n_pass++;
  endtask

  task automatic test_rst_mid_release();
    locked = 1'b1;
    do_reset();
    repeat (14) step();
    n_checks++;
    if (rst_out !== 3'b100) $display("FAIL mid_release_pre: got %b want 100", rst_out);
    else n_pass++;
    rst = 1'b1;
    restart = 1'b1;
    step();
    n_checks++;
    if ({pll_rst, rst_out, ready} !== 5'b1_111_0)
      $display("FAIL mid_release_rst: got %b want %b", {pll_rst, rst_out, ready}, 5'b1_111_0);
    else n_pass++;
`ifdef PLL_SEQ_RETRY_CNT_EN
    n_checks++;
    if (retry_cnt !== 8'd0) $display("FAIL mid_release_retry: got %0d want 0", retry_cnt);
    else n_pass++;
`endif
    rst = 1'b0;
    restart = 1'b0;
  endtask

  task automatic test_random();
    locked = 1'b1;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      n_checks++;
      if ({pll_rst, rst_out, ready} !== exp_outs())
        $display("FAIL random cyc %0d: got %b want %b", i, {pll_rst, rst_out, ready}, exp_outs());
      else n_pass++;
`ifdef PLL_SEQ_RETRY_CNT_EN
      n_checks++;
      if (retry_cnt !== 8'(m_retry))
        $display("FAIL random_retry cyc %0d: got %0d want %0d", i, retry_cnt, m_retry);
      else n_pass++;
`endif
      if ($urandom_range(0, 29) == 0) locked = ~locked;
      restart = ($urandom_range(0, 149) == 0);
      rst     = ($urandom_range(0, 799) == 0);
      step();
    end
    rst = 1'b0;
    restart = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    locked = 1'b0;
    restart = 1'b0;
    m_retry = 0;
    go_reset_phase(1'b0);
    m_l1 = 1'b0;
    m_l2 = 1'b0;
    test_reset();
    test_lock_held();
    test_timeout();
    test_glitch();
    test_lock_loss();
    test_restart_with_loss();
    test_restart_in_reset();
    test_rst_mid_release();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
